// File: rtl/pattern_bit_sequencer.sv
// Captures a WIDTH-bit pattern and streams selected bits one at a time from a start index.
// Latency: first bit (or done/err pulse) is visible the cycle after the accepted start.
// Backpressure: while valid_o is high and ready_i is low, bit_o/idx_o/valid_o hold.
module pattern_bit_sequencer #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [IDX_W-1:0] first_idx_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             bit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pat;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rem;
  logic             first_ok;
  logic             take;
  logic             xfer;

  // Index range check only matters for non-power-of-2 widths; the zero
  // extension keeps the compare meaningful when WIDTH == 2**IDX_W.
  assign first_ok = ({1'b0, first_idx_i} < CNT_W'(WIDTH));
  assign take     = (state == IDLE) && start_i && first_ok && (count_i != '0);
  assign xfer     = (state == RUN) && ready_i;

  // State register plus the captured pattern, current index and bits remaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat   <= '0;
      idx   <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        pat <= pattern_i;
        idx <= first_idx_i;
        rem <= count_i;
      end else if (xfer) begin
        idx <= (idx == IDX_W'(WIDTH - 1)) ? '0 : idx + IDX_W'(1);
        rem <= rem - CNT_W'(1);
      end
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (!first_ok)            state_nxt = ERR;
          else if (count_i == '0)   state_nxt = DONE;
          else                      state_nxt = RUN;
        end
      end
      RUN:     if (ready_i && (rem == CNT_W'(1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come from registered state only, so nothing from an input reaches an output combinationally.
  assign valid_o = (state == RUN);
  assign bit_o   = valid_o & pat[idx];
  assign idx_o   = valid_o ? idx : '0;
  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign err_o   = (state == ERR);

endmodule

// File: tb/tb_pattern_bit_sequencer.sv
// Self-checking bench: WIDTH=8 main instance with a scoreboard, plus WIDTH=2 and WIDTH=6 instances.
// Latency: expects the first bit / done / err one cycle after the accepted start.
// Backpressure: ready is driven stalled, random or always-high and held outputs are checked.
module tb_pattern_bit_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       s8, r8, b8, v8, y8, d8, e8;
  logic [7:0] p8;
  logic [2:0] f8, i8;
  logic [3:0] c8;
  // WIDTH=2 instance
  logic       s2, r2, b2, v2, y2, d2, e2;
  logic [1:0] p2, c2;
  logic [0:0] f2, i2;
  // WIDTH=6 instance
  logic       s6, r6, b6, v6, y6, d6, e6;
  logic [5:0] p6;
  logic [2:0] f6, i6;
  logic [3:0] c6;

  pattern_bit_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_i(s8), .pattern_i(p8), .first_idx_i(f8), .count_i(c8),
    .bit_o(b8), .idx_o(i8), .valid_o(v8), .ready_i(r8), .busy_o(y8), .done_o(d8), .err_o(e8));
  pattern_bit_sequencer #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start_i(s2), .pattern_i(p2), .first_idx_i(f2), .count_i(c2),
    .bit_o(b2), .idx_o(i2), .valid_o(v2), .ready_i(r2), .busy_o(y2), .done_o(d2), .err_o(e2));
  pattern_bit_sequencer #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .start_i(s6), .pattern_i(p6), .first_idx_i(f6), .count_i(c6),
    .bit_o(b6), .idx_o(i6), .valid_o(v6), .ready_i(r6), .busy_o(y6), .done_o(d6), .err_o(e6));

  int vec = 0;
  int bad = 0;
  logic [3:0] sbq[$];   // expected {idx, bit} for the WIDTH=8 instance

  // Reference model: bit sequence of a start, pushed when the start is driven.
  task automatic push_model(input logic [7:0] p, input int f, input int n);
    for (int k = 0; k < n; k++) begin
      int ix;
      logic [31:0] ixv;
      ix  = (f + k) % 8;
      ixv = ix;
      sbq.push_back({ixv[2:0], p[ix]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s8 = 0; p8 = 0; f8 = 0; c8 = 0; r8 = 0;
    s2 = 0; p2 = 0; f2 = 0; c2 = 0; r2 = 0;
    s6 = 0; p6 = 0; f6 = 0; c6 = 0; r6 = 0;
    repeat (3) @(negedge clk);
    vec++;
    if ({b8, i8, v8, y8, d8, e8} !== 8'd0) begin
      bad++; $display("FAIL reset_w8: got %b want 0", {b8, i8, v8, y8, d8, e8});
    end
    vec++;
    if ({b2, i2, v2, y2, d2, e2} !== 6'd0) begin
      bad++; $display("FAIL reset_w2: got %b want 0", {b2, i2, v2, y2, d2, e2});
    end
    vec++;
    if ({b6, i6, v6, y6, d6, e6} !== 8'd0) begin
      bad++; $display("FAIL reset_w6: got %b want 0", {b6, i6, v6, y6, d6, e6});
    end
    rst = 1'b0;
  endtask

  // mode 0: ready always high; 1: 3-cycle stall on the second bit;
  // 2: random ready; 3: ready high with start re-asserted (junk inputs) through the end.
  task automatic test_stream(input string name, input logic [7:0] p, input int f,
                             input int n, input int mode);
    int   last, xfers, stalls;
    bit   fin, held;
    logic pb;
    logic [2:0] pi;
    logic [3:0] exp;
    last = 0; xfers = 0; stalls = 0; fin = 0; held = 0; pb = 0; pi = 0;
    sbq.delete();
    push_model(p, f, n);
    s8 = 1'b1; p8 = p; f8 = 3'(f); c8 = 4'(n); r8 = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      s8 = (mode == 3) && (c >= 2);
      p8 = 8'($urandom); f8 = 3'($urandom); c8 = 4'($urandom);
      case (mode)
        1:       r8 = !((xfers == 1) && (stalls < 3));
        2:       r8 = 1'($urandom_range(0, 1));
        default: r8 = 1'b1;
      endcase
      if (!r8) stalls++;
      if (held) begin
        vec++;
        if (!(v8 === 1'b1 && i8 === pi && b8 === pb)) begin
          bad++; $display("FAIL %s_hold: got v=%b idx=%0d bit=%b want v=1 idx=%0d bit=%b",
                          name, v8, i8, b8, pi, pb);
        end
      end
      if (v8 !== 1'b1) begin
        vec++;
        if ({i8, b8} !== 4'd0) begin
          bad++; $display("FAIL %s_idle_zero: got idx=%0d bit=%b want 0", name, i8, b8);
        end
      end
      if (v8 === 1'b1 && r8) begin
        vec++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL %s_extra: got idx=%0d bit=%b want no transfer", name, i8, b8);
        end else begin
          exp = sbq.pop_front();
          if ({i8, b8} !== exp) begin
            bad++; $display("FAIL %s_bit: got idx=%0d bit=%b want idx=%0d bit=%b",
                            name, i8, b8, exp[3:1], exp[0]);
          end
        end
        last = c; xfers++;
      end
      held = (v8 === 1'b1) && !r8; pi = i8; pb = b8;
      if (d8 === 1'b1) begin
        fin = 1;
        vec++;
        if (c != last + 1 || sbq.size() != 0 || y8 !== 1'b1) begin
          bad++; $display("FAIL %s_done: got cycle=%0d left=%0d busy=%b want cycle=%0d left=0 busy=1",
                          name, c, sbq.size(), y8, last + 1);
        end
        break;
      end
    end
    if (!fin) begin
      vec++; bad++; $display("FAIL %s_timeout: got no done want done", name);
    end
    if (mode == 0) begin
      vec++;
      if (last != n) begin
        bad++; $display("FAIL %s_b2b: got last xfer cycle %0d want %0d", name, last, n);
      end
    end
    @(negedge clk);
    s8 = 1'b0;
    vec++;
    if ({y8, d8, v8} !== 3'b000) begin
      bad++; $display("FAIL %s_idle: got busy/done/valid=%b want 000", name, {y8, d8, v8});
    end
  endtask

  task automatic test_w2_single();
    s2 = 1; p2 = 2'b10; f2 = 1'b1; c2 = 2'd1; r2 = 1;
    @(negedge clk); s2 = 0;
    vec++;
    if ({v2, i2, b2, d2} !== 4'b1110) begin
      bad++; $display("FAIL w2_bit: got v/idx/bit/done=%b want 1110", {v2, i2, b2, d2});
    end
    @(negedge clk);
    vec++;
    if ({v2, d2, y2} !== 3'b011) begin
      bad++; $display("FAIL w2_done: got v/done/busy=%b want 011", {v2, d2, y2});
    end
    @(negedge clk);
    vec++;
    if ({v2, d2, y2} !== 3'b000) begin
      bad++; $display("FAIL w2_idle: got v/done/busy=%b want 000", {v2, d2, y2});
    end
  endtask

  task automatic test_count_zero();
    s8 = 1; p8 = 8'hFF; f8 = 3'd3; c8 = 4'd0; r8 = 1;
    @(negedge clk); s8 = 0;
    vec++;
    if ({v8, d8, y8, e8} !== 4'b0110) begin
      bad++; $display("FAIL cnt0_done: got v/done/busy/err=%b want 0110", {v8, d8, y8, e8});
    end
    @(negedge clk);
    vec++;
    if ({v8, d8, y8} !== 3'b000) begin
      bad++; $display("FAIL cnt0_idle: got v/done/busy=%b want 000", {v8, d8, y8});
    end
  endtask

  task automatic test_err_w6();
    s6 = 1; p6 = 6'h3F; f6 = 3'd6; c6 = 4'd3; r6 = 1;
    @(negedge clk); s6 = 0;
    vec++;
    if ({v6, e6, y6, d6} !== 4'b0110) begin
      bad++; $display("FAIL w6_err: got v/err/busy/done=%b want 0110", {v6, e6, y6, d6});
    end
    @(negedge clk);
    vec++;
    if ({v6, e6, y6} !== 3'b000) begin
      bad++; $display("FAIL w6_idle: got v/err/busy=%b want 000", {v6, e6, y6});
    end
    // Legal start on the odd width: index 5 must wrap to 0.
    s6 = 1; p6 = 6'b100000; f6 = 3'd5; c6 = 4'd2;
    @(negedge clk); s6 = 0;
    vec++;
    if ({v6, i6, b6} !== 5'b1_101_1) begin
      bad++; $display("FAIL w6_bit5: got v/idx/bit=%b want 11011", {v6, i6, b6});
    end
    @(negedge clk);
    vec++;
    if ({v6, i6, b6} !== 5'b1_000_0) begin
      bad++; $display("FAIL w6_wrap: got v/idx/bit=%b want 10000", {v6, i6, b6});
    end
    @(negedge clk);
    vec++;
    if ({v6, d6} !== 2'b01) begin
      bad++; $display("FAIL w6_done: got v/done=%b want 01", {v6, d6});
    end
  endtask

  task automatic test_reset_mid_run();
    s8 = 1; p8 = 8'hFF; f8 = 3'd0; c8 = 4'd8; r8 = 1;
    @(negedge clk); s8 = 0;
    @(negedge clk);
    rst = 1; r8 = 0;
    @(negedge clk);
    vec++;
    if ({b8, i8, v8, y8, d8, e8} !== 8'd0) begin
      bad++; $display("FAIL midrst_zero: got %b want 0", {b8, i8, v8, y8, d8, e8});
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++;
      if ({d8, y8, v8} !== 3'b000) begin
        bad++; $display("FAIL midrst_quiet: got done/busy/valid=%b want 000", {d8, y8, v8});
      end
    end
  endtask

  initial begin
    test_reset();
    test_w2_single();
    test_stream("a5_b2b", 8'hA5, 6, 4, 0);
    test_stream("a5_stall", 8'hA5, 6, 4, 1);
    test_count_zero();
    test_err_w6();
    test_stream("ignore_start", 8'hA5, 0, 6, 3);
    test_reset_mid_run();
    test_stream("after_rst", 8'h04, 2, 2, 0);
    test_stream("wrap_0f", 8'h0F, 0, 10, 0);
    test_stream("rand_ready", 8'($urandom), $urandom_range(0, 7), 12, 2);
    test_stream("max_cnt", 8'h96, 7, 15, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/pattern_bit_sequencer.md
Name: pattern_bit_sequencer

Overview:
- Sequencer for a constant-pattern bit-select datapath: captures a WIDTH-bit pattern and emits selected bits one at a time, starting at a given index.
- The index increments modulo WIDTH.
- Each bit is delivered on a valid/ready stream.
- Used as the controller that drives successive bit selects of a pattern vector, for example reading bit 1 of 2'b10, in synthesis-frontend regression designs.

Parameters:
- WIDTH, 8, pattern width in bits. Must be >= 2.
- IDX_W, $clog2(WIDTH), index width. Derived; not overridden.
- CNT_W, IDX_W+1, width of the bit-count request.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request pulse; sampled only in IDLE
- pattern_i  input  WIDTH  pattern captured on an accepted start
- first_idx_i  input  IDX_W  first bit index to emit
- count_i  input  CNT_W  number of bits to emit
- bit_o  output  1  selected pattern bit
- idx_o  output  IDX_W  index of the bit currently on bit_o
- valid_o  output  1  bit_o/idx_o valid
- ready_i  input  1  consumer accepts the current bit
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse at the end of a sequence
- err_o  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: synchronous, active-high. On the next clk edge all outputs go to 0, state goes to IDLE, and internal pattern/idx/remaining registers clear to 0. Reset has priority over every other event, including mid-sequence; a sequence interrupted by reset produces no done_o.
- States: IDLE, RUN, DONE, ERR.
- IDLE, start_i=1 at edge N:
  - If first_idx_i >= WIDTH (possible only for non-power-of-2 WIDTH): go to ERR.
  - Else if count_i == 0: go to DONE. No bits are emitted.
  - Else: capture pat <= pattern_i, idx <= first_idx_i, rem <= count_i, and go to RUN.
- Latency: valid_o rises in the cycle after edge N. done_o/err_o likewise appear in the cycle after edge N.
- RUN outputs: valid_o=1, bit_o = pat[idx], idx_o = idx, busy_o=1.
- RUN handshake (valid_o & ready_i at an edge):
  - idx <= (idx == WIDTH-1) ? 0 : idx+1
  - rem <= rem-1
  - If rem == 1: go to DONE with valid_o=0 in the next cycle.
- Back-to-back transfers: with ready_i held high, one bit transfers per cycle.
- Backpressure: while valid_o=1 and ready_i=0, bit_o, idx_o and valid_o hold stable. valid_o never drops without a transfer, except on rst.
- DONE: done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
- ERR: err_o=1 and busy_o=1 for exactly one cycle, then IDLE. No bits are emitted.
- start_i while busy_o=1 is ignored and not queued. A start_i in the same cycle that DONE/ERR returns to IDLE is also ignored; start is only sampled while state is IDLE.
- Wrap-around: count_i > WIDTH is legal. The index keeps wrapping and the pattern repeats.
- Stable capture: pattern_i, first_idx_i and count_i are don't-care outside the start cycle. Changes during RUN have no effect.
- bit_o and idx_o are 0 whenever valid_o=0.
- All outputs are registered or derived only from state registers. There is no combinational path from any input to any output.

Test Plan:
1. WIDTH=2, pattern 2'b10, first_idx=1, count=1, ready=1.
   -> one transfer with bit_o=1, idx_o=1; done_o pulses in the cycle after the transfer; a=bit matches 1'b1.
2. WIDTH=8, pattern 8'hA5, first_idx=6, count=4, ready=1.
   -> transfers (idx,bit) = (6,0),(7,1),(0,1),(1,0) on 4 consecutive cycles, then done_o pulse, then busy_o=0.
3. Same as 2, with ready_i low for 3 cycles during the second bit.
   -> idx_o=7, bit_o=1, valid_o=1 held for 3 cycles; the total sequence and order are unchanged.
4. count=0 start.
   -> no valid_o; done_o pulses the cycle after start. Then WIDTH=6, first_idx=6 -> err_o pulse, no valid_o, back to IDLE.
5. start_i re-asserted during RUN with a different pattern.
   -> ignored; the original bits continue. After reset asserted mid-RUN: all outputs 0 the next cycle, no done_o, and a new start is accepted normally.
6. pattern 8'h0F, first_idx=0, count=10.
   -> bits 1,1,1,1,0,0,0,0,1,1 with idx wrapping 7 -> 0, then done_o.
